// File: rtl/ex_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_unit
// Purpose  : Execute stage with ALU, branch resolution and EX/MEM register.
//            MULDIV_EN adds an iterative multiply/divide unit that stalls upstream.
// Revision : 1.0
// ============================================================================
module ex_stage_unit #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   inPc,
    input  logic [DATA_W-1:0] inReadData1,
    input  logic [DATA_W-1:0] inReadData2,
    input  logic [DATA_W-1:0] inSignExtImm,
    input  logic [4:0]        inRb,
    input  logic [4:0]        inRd,
    input  logic              inRegDst,
    input  logic              inALUSrc,
    input  logic              inMemToReg,
    input  logic              inRegWrite,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic              inBranch,
    input  logic [OP_W-1:0]   inALUOp,
    output logic [DATA_W-1:0] outAluResult,
    output logic [DATA_W-1:0] outWriteData,
    output logic [4:0]        outWriteReg,
    output logic              outMemToReg,
    output logic              outRegWrite,
    output logic              outMemRead,
    output logic              outMemWrite,
    output logic              outBranchTaken,
    output logic [PC_W-1:0]   outBranchTarget,
    output logic              outStall
);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(7);

    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_result;
    logic              w_taken;
    logic [PC_W-1:0]   w_target;

    assign w_b      = inALUSrc ? inSignExtImm : inReadData2;
    assign w_taken  = inBranch & (inReadData1 == w_b);
    assign w_target = inPc + inSignExtImm[PC_W-1:0];

    always_comb begin
        w_alu = '0;
        case (inALUOp)
            OP_ADD:  w_alu = inReadData1 + w_b;
            OP_SUB:  w_alu = inReadData1 - w_b;
            OP_AND:  w_alu = inReadData1 & w_b;
            OP_OR:   w_alu = inReadData1 | w_b;
            OP_XOR:  w_alu = inReadData1 ^ w_b;
            OP_SLL:  w_alu = inReadData1 << w_b[4:0];
            OP_SRL:  w_alu = inReadData1 >> w_b[4:0];
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(inReadData1) < $signed(w_b))};
            default: w_alu = '0;
        endcase
    end

`ifdef MULDIV_EN
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_DIVU = OP_W'(9);
    localparam logic [OP_W-1:0] OP_REMU = OP_W'(10);
    localparam int              CNT_W   = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [OP_W-1:0]   mdop_q;
    logic [DATA_W-1:0] acc_q;     // product (MUL) or partial remainder (DIV/REM)
    logic [DATA_W-1:0] shift_q;   // shifting multiplicand, or dividend becoming quotient
    logic [DATA_W-1:0] opb_q;     // shifting multiplier, or divisor

    logic              w_is_md;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_nx;
    logic [DATA_W-1:0] w_prod_nx;
    logic [DATA_W-1:0] w_md_res;

    assign w_is_md  = (inALUOp == OP_MUL) | (inALUOp == OP_DIVU) | (inALUOp == OP_REMU);
    assign outStall = rst & (((state_q == S_IDLE) & w_is_md) | (state_q == S_BUSY));

    // Partial remainder is always below the divisor, so a clear borrow bit means "fits".
    assign w_rem_sh  = {acc_q, shift_q[DATA_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, opb_q};
    assign w_ge      = ~w_diff[DATA_W];
    assign w_rem_nx  = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    assign w_prod_nx = acc_q + (opb_q[0] ? shift_q : '0);

    always_comb begin
        w_md_res = '0;
        case (mdop_q)
            OP_MUL:  w_md_res = acc_q;
            OP_DIVU: w_md_res = shift_q;
            OP_REMU: w_md_res = acc_q;
            default: w_md_res = '0;
        endcase
    end

    assign w_result = (state_q == S_DONE) ? w_md_res : w_alu;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            mdop_q  <= '0;
            acc_q   <= '0;
            shift_q <= '0;
            opb_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_md) begin
                        state_q <= S_BUSY;
                        count_q <= CNT_W'(DATA_W-1);
                        mdop_q  <= inALUOp;
                        acc_q   <= '0;
                        shift_q <= inReadData1;
                        opb_q   <= w_b;
                    end
                end
                S_BUSY: begin
                    if (mdop_q == OP_MUL) begin
                        acc_q   <= w_prod_nx;
                        shift_q <= shift_q << 1;
                        opb_q   <= opb_q >> 1;
                    end else begin
                        acc_q   <= w_rem_nx;
                        shift_q <= {shift_q[DATA_W-2:0], w_ge};
                    end
                    if (count_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    assign outStall = 1'b0;
    assign w_result = w_alu;
`endif

    // While stalled, control goes out as a bubble and data outputs keep their value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outAluResult    <= '0;
            outWriteData    <= '0;
            outWriteReg     <= '0;
            outMemToReg     <= 1'b0;
            outRegWrite     <= 1'b0;
            outMemRead      <= 1'b0;
            outMemWrite     <= 1'b0;
            outBranchTaken  <= 1'b0;
            outBranchTarget <= '0;
        end else if (outStall) begin
            outMemToReg    <= 1'b0;
            outRegWrite    <= 1'b0;
            outMemRead     <= 1'b0;
            outMemWrite    <= 1'b0;
            outBranchTaken <= 1'b0;
        end else begin
            outAluResult    <= w_result;
            outWriteData    <= inReadData2;
            outWriteReg     <= inRegDst ? inRd : inRb;
            outMemToReg     <= inMemToReg;
            outRegWrite     <= inRegWrite;
            outMemRead      <= inMemRead;
            outMemWrite     <= inMemWrite;
            outBranchTaken  <= w_taken;
            outBranchTarget <= w_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_unit.sv
`default_nettype none
// Testbench for ex_stage_unit: scoreboard of expected EX/MEM contents per issued instruction.
module tb_ex_stage_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  inPc = '0;
    logic [31:0] inReadData1 = '0, inReadData2 = '0, inSignExtImm = '0;
    logic [4:0]  inRb = '0, inRd = '0;
    logic        inRegDst = 0, inALUSrc = 0, inMemToReg = 0, inRegWrite = 0;
    logic        inMemRead = 0, inMemWrite = 0, inBranch = 0;
    logic [4:0]  inALUOp = '0;
    logic [31:0] outAluResult, outWriteData;
    logic [4:0]  outWriteReg;
    logic        outMemToReg, outRegWrite, outMemRead, outMemWrite, outBranchTaken, outStall;
    logic [7:0]  outBranchTarget;

    ex_stage_unit #(.DATA_W(32), .PC_W(8), .OP_W(5)) dut (
        .clk(clk), .rst(rst), .inPc(inPc), .inReadData1(inReadData1),
        .inReadData2(inReadData2), .inSignExtImm(inSignExtImm), .inRb(inRb), .inRd(inRd),
        .inRegDst(inRegDst), .inALUSrc(inALUSrc), .inMemToReg(inMemToReg),
        .inRegWrite(inRegWrite), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inBranch(inBranch), .inALUOp(inALUOp), .outAluResult(outAluResult),
        .outWriteData(outWriteData), .outWriteReg(outWriteReg), .outMemToReg(outMemToReg),
        .outRegWrite(outRegWrite), .outMemRead(outMemRead), .outMemWrite(outMemWrite),
        .outBranchTaken(outBranchTaken), .outBranchTarget(outBranchTarget), .outStall(outStall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [3:0]  ctrl;
        logic        btaken;
        logic [7:0]  btarget;
    } exp_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        alusrc;
        logic        regdst;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } vec_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = '0;

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef MULDIV_EN
            5'd8:  return a * b;
            5'd9:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd10: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic alusrc, input logic regdst,
                         input logic [4:0] rb, input logic [4:0] rd, input logic [3:0] ctrl,
                         input logic br, input logic [7:0] pc);
        exp_t        e;
        logic [31:0] bv;
        inALUOp = op; inReadData1 = a; inReadData2 = b; inSignExtImm = imm;
        inALUSrc = alusrc; inRegDst = regdst; inRb = rb; inRd = rd;
        {inMemToReg, inRegWrite, inMemRead, inMemWrite} = ctrl;
        inBranch = br; inPc = pc;
        bv        = alusrc ? imm : b;
        e.res     = ref_alu(op, a, bv);
        e.wdata   = b;
        e.wreg    = regdst ? rd : rb;
        e.ctrl    = ctrl;
        e.btaken  = br && (a == bv);
        e.btarget = pc + imm[7:0];
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        drive(5'd0, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1, 5'd3, 5'd7, 4'b1111, 1'b0, 8'h10);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (outAluResult !== e.res) begin
            errors++; $display("FAIL pre_reset_add got=%h exp=%h", outAluResult, e.res);
        end
        drive(5'd0, 32'h5, 32'h5, 32'h4, 1'b0, 1'b1, 5'd3, 5'd7, 4'b1111, 1'b1, 8'h20);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        checks++;
        if ({outAluResult, outWriteData, outWriteReg, outBranchTarget} !== '0) begin
            errors++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", outAluResult, outWriteData, outWriteReg, outBranchTarget);
        end
        checks++;
        if ({outMemToReg, outRegWrite, outMemRead, outMemWrite, outBranchTaken, outStall} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000",
                {outMemToReg, outRegWrite, outMemRead, outMemWrite, outBranchTaken, outStall});
        end
        rst = 1'b1;
        last_res = '0;
    endtask

    task automatic test_alu();
        vec_t v[12];
        exp_t e;
        v = '{
            '{5'd0,  32'hFFFF_FFFF, 32'd1,          32'd0, 1'b0, 1'b0, 5'd1, 5'd2,  4'b0100},
            '{5'd1,  32'd0,         32'd1,          32'd0, 1'b0, 1'b1, 5'd1, 5'd2,  4'b0100},
            '{5'd2,  32'hF0F0_1234, 32'h0FF0_FF00,  32'd0, 1'b0, 1'b0, 5'd3, 5'd4,  4'b0010},
            '{5'd3,  32'hF000_0000, 32'h0000_000F,  32'd0, 1'b0, 1'b0, 5'd5, 5'd6,  4'b0001},
            '{5'd4,  32'hAAAA_5555, 32'hFFFF_0000,  32'd0, 1'b0, 1'b0, 5'd7, 5'd8,  4'b1100},
            '{5'd5,  32'd3,         32'h1234,       32'd5, 1'b1, 1'b1, 5'd4, 5'd9,  4'b0100},
            '{5'd6,  32'h8000_0000, 32'h0000_003F,  32'd0, 1'b0, 1'b0, 5'd10, 5'd11, 4'b0100},
            '{5'd7,  32'hFFFF_FFFF, 32'd1,          32'd0, 1'b0, 1'b0, 5'd12, 5'd13, 4'b0100},
            '{5'd7,  32'd1,         32'hFFFF_FFFF,  32'd0, 1'b0, 1'b0, 5'd14, 5'd15, 4'b0100},
            '{5'd31, 32'h1234_5678, 32'h1111_1111,  32'd0, 1'b0, 1'b0, 5'd16, 5'd17, 4'b0000},
            '{5'd13, 32'h1234_5678, 32'h1111_1111,  32'd0, 1'b0, 1'b0, 5'd18, 5'd19, 4'b0100},
            '{5'd0,  32'h0000_0100, 32'hDEAD_BEEF,  32'hFFFF_FFFF, 1'b1, 1'b1, 5'd20, 5'd21, 4'b1010}
        };
        for (int i = 0; i < 12; i++) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].alusrc, v[i].regdst,
                  v[i].rb, v[i].rd, v[i].ctrl, 1'b0, 8'h00);
            @(posedge clk); #1;
            e = sb.pop_front();
            last_res = e.res;
            checks++;
            if (outAluResult !== e.res) begin
                errors++; $display("FAIL alu_result[%0d] got=%h exp=%h", i, outAluResult, e.res);
            end
            checks++;
            if (outWriteReg !== e.wreg || outWriteData !== e.wdata) begin
                errors++; $display("FAIL alu_wb[%0d] got=%0d/%h exp=%0d/%h", i, outWriteReg, outWriteData, e.wreg, e.wdata);
            end
            checks++;
            if ({outMemToReg, outRegWrite, outMemRead, outMemWrite} !== e.ctrl) begin
                errors++; $display("FAIL alu_ctrl[%0d] got=%b exp=%b", i,
                    {outMemToReg, outRegWrite, outMemRead, outMemWrite}, e.ctrl);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(5'd1, 32'h10, 32'h10, 32'd4, 1'b0, 1'b0, 5'd0, 5'd0, 4'b0000, 1'b1, 8'hFE);
                1: drive(5'd1, 32'h10, 32'h11, 32'd4, 1'b0, 1'b0, 5'd0, 5'd0, 4'b0000, 1'b1, 8'h40);
                default: drive(5'd1, 32'h10, 32'h10, 32'hF0, 1'b0, 1'b0, 5'd0, 5'd0, 4'b0000, 1'b0, 8'h20);
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            last_res = e.res;
            checks++;
            if (outBranchTaken !== e.btaken) begin
                errors++; $display("FAIL branch_taken[%0d] got=%b exp=%b", i, outBranchTaken, e.btaken);
            end
            checks++;
            if (outBranchTarget !== e.btarget) begin
                errors++; $display("FAIL branch_target[%0d] got=%h exp=%h", i, outBranchTarget, e.btarget);
            end
        end
    endtask

`ifdef MULDIV_EN
    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        drive(op, a, b, 32'd0, 1'b0, 1'b1, 5'd2, 5'd12, 4'b0100, 1'b0, 8'h00);
        #1;
        n = outStall ? 1 : 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({outMemToReg, outRegWrite, outMemRead, outMemWrite, outBranchTaken} !== 5'b0) begin
                errors++; $display("FAIL md_bubble op=%0d cyc=%0d got=%b exp=00000", op, k,
                    {outMemToReg, outRegWrite, outMemRead, outMemWrite, outBranchTaken});
            end
            checks++;
            if (outAluResult !== last_res) begin
                errors++; $display("FAIL md_hold op=%0d cyc=%0d got=%h exp=%h", op, k, outAluResult, last_res);
            end
            if (!outStall) break;
            n++;
        end
        checks++;
        if (n != 33) begin
            errors++; $display("FAIL md_stall_len op=%0d got=%0d exp=33", op, n);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        last_res = e.res;
        checks++;
        if (outAluResult !== e.res) begin
            errors++; $display("FAIL md_result op=%0d got=%h exp=%h", op, outAluResult, e.res);
        end
        checks++;
        if (outWriteReg !== e.wreg || {outMemToReg, outRegWrite, outMemRead, outMemWrite} !== e.ctrl) begin
            errors++; $display("FAIL md_wb op=%0d got=%0d/%b exp=%0d/%b", op, outWriteReg,
                {outMemToReg, outRegWrite, outMemRead, outMemWrite}, e.wreg, e.ctrl);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        run_md(5'd8,  32'd7, 32'd6);
        run_md(5'd9,  32'd100, 32'd7);
        run_md(5'd10, 32'd100, 32'd7);
        run_md(5'd9,  32'hDEAD_BEEF, 32'd0);
        run_md(5'd10, 32'hDEAD_BEEF, 32'd0);
        run_md(5'd8,  32'h1234_5678, 32'h9ABC_DEF0);
        run_md(5'd9,  32'hFFFF_FFFF, 32'h0000_0003);
        drive(5'd0, 32'd40, 32'd2, 32'd0, 1'b0, 1'b0, 5'd6, 5'd0, 4'b0100, 1'b0, 8'h00);
        #1;
        checks++;
        if (outStall !== 1'b0) begin
            errors++; $display("FAIL md_followup_stall got=%b exp=0", outStall);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        last_res = e.res;
        checks++;
        if (outAluResult !== e.res) begin
            errors++; $display("FAIL md_followup_add got=%h exp=%h", outAluResult, e.res);
        end
    endtask

    task automatic test_md_reset();
        drive(5'd8, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 5'd2, 5'd12, 4'b0100, 1'b0, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(5'd31, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 4'b0000, 1'b0, 8'h00);
        @(posedge clk); #1;
        sb.delete();
        checks++;
        if (outStall !== 1'b0 || outAluResult !== 32'd0) begin
            errors++; $display("FAIL mdrst_now got=%b/%h exp=0/0", outStall, outAluResult);
        end
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            checks++;
            if (outStall !== 1'b0 || outAluResult !== 32'd0 || outRegWrite !== 1'b0) begin
                errors++; $display("FAIL mdrst_after cyc=%0d got=%b/%h/%b exp=0/0/0", k, outStall, outAluResult, outRegWrite);
            end
        end
        last_res = '0;
    endtask
`else
    task automatic test_md_disabled();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(5'(8 + i), 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 5'd2, 5'd12, 4'b0100, 1'b0, 8'h00);
            #1;
            checks++;
            if (outStall !== 1'b0) begin
                errors++; $display("FAIL mdoff_stall[%0d] got=%b exp=0", i, outStall);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            last_res = e.res;
            checks++;
            if (outAluResult !== e.res || outRegWrite !== e.ctrl[2]) begin
                errors++; $display("FAIL mdoff_result[%0d] got=%h/%b exp=%h/%b", i, outAluResult, outRegWrite, e.res, e.ctrl[2]);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_alu();
        test_branch();
`ifdef MULDIV_EN
        test_back_to_back();
        test_md_reset();
`else
        test_md_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
